decode_input_queue: RTL and testbench

- Small in-order FIFO between the instruction re-aligner/compressed expander and the decoder.
- Buffers fetched, already-expanded instructions with their PC, compressed form, illegal flag, branch prediction and fetch exception.
- Presents the oldest entry to the decoder under a valid/ready handshake.
- Decouples fetch bubbles from decode stalls and supports a single-cycle flush on mispredict or exception.

---
 rtl/decode_input_queue_pkg.sv | 16 +
 rtl/decode_input_queue.sv | 61 ++++++
 tb/tb_decode_input_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/decode_input_queue_pkg.sv
// decode_input_queue_pkg: shared fetch/decode entry type and widths for the decode input queue
package decode_input_queue_pkg;
  localparam int unsigned VLEN = 64;
  localparam int unsigned EX_CAUSE_W = 6;
  typedef struct packed {
    logic [VLEN-1:0]       pc;
    logic [31:0]           instr;
    logic                  is_compressed;
    logic [15:0]           cinstr;
    logic                  is_illegal;
    logic                  bp_taken;
    logic [VLEN-1:0]       bp_target;
    logic                  ex_valid;
    logic [EX_CAUSE_W-1:0] ex_cause;
  } fetch_entry_t;
endpackage

// File: rtl/decode_input_queue.sv
// decode_input_queue: in-order FIFO of expanded fetch entries feeding the decoder.
// Virtual address width comes from decode_input_queue_pkg::VLEN.
// Define DECODE_QUEUE_BYPASS_EN to forward a fetch entry straight to decode when
// the queue is empty and the decoder is ready (zero-cycle latency).
module decode_input_queue
  import decode_input_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  fetch_entry_t               fetch_entry_i,
  output logic                       decode_valid_o,
  input  logic                       decode_ready_i,
  output fetch_entry_t               decode_entry_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          push, pop, bypass, empty;
  // handshakes, optional empty-queue bypass and next pointer/count state
  always_comb begin
    empty          = count_q == '0;
`ifdef DECODE_QUEUE_BYPASS_EN
    bypass         = empty && fetch_valid_i && decode_ready_i && !flush_i;
`else
    bypass         = 1'b0;
`endif
    fetch_ready_o  = count_q < CW'(DEPTH);
    decode_valid_o = (!empty || bypass) && !flush_i;
    decode_entry_o = bypass ? fetch_entry_i : mem_q[rd_ptr_q];
    push           = fetch_valid_i && fetch_ready_o && !flush_i && !bypass;
    pop            = !empty && decode_ready_i && !flush_i;
    rd_ptr_d       = flush_i ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d       = flush_i ? '0 : wr_ptr_q + PW'(push);
    count_d        = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    count_o        = count_q;
  end
  // pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  // entry storage is never reset; validity is tracked by the count alone
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= fetch_entry_i;
  end
endmodule

// File: tb/tb_decode_input_queue.sv
// tb_decode_input_queue: table-driven and randomized checks of decode_input_queue against a queue model
module tb_decode_input_queue;
  import decode_input_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, fv = 1'b0, dr = 1'b0;
  logic fetch_ready, decode_valid;
  fetch_entry_t fin, dout;
  logic [$clog2(DEPTH):0] count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  decode_input_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fetch_valid_i(fv), .fetch_ready_o(fetch_ready), .fetch_entry_i(fin),
    .decode_valid_o(decode_valid), .decode_ready_i(dr), .decode_entry_o(dout),
    .count_o(count)
  );
  typedef struct {
    logic fv, dr, fl;
    logic [63:0] pc;
    logic ev, er;
    int ec;
    logic [63:0] epc;
  } vec_t;
  vec_t tbl[$];
  fetch_entry_t model[$];
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic fetch_entry_t mk(input logic [63:0] pc);
    fetch_entry_t e;
    e = '0;
    e.pc = pc;
    e.instr = pc[31:0] ^ 32'h13;
    e.bp_target = pc + 64'h40;
    e.ex_cause = pc[7:2];
    return e;
  endfunction
  function automatic fetch_entry_t rnd_entry();
    fetch_entry_t e;
    e.pc = {$urandom, $urandom};
    e.instr = $urandom;
    e.is_compressed = 1'($urandom);
    e.cinstr = 16'($urandom);
    e.is_illegal = 1'($urandom);
    e.bp_taken = 1'($urandom);
    e.bp_target = {$urandom, $urandom};
    e.ex_valid = 1'($urandom);
    e.ex_cause = 6'($urandom);
    return e;
  endfunction
  function automatic vec_t v(input logic f, input logic d, input logic l, input logic [63:0] pc,
                             input logic ev, input logic er, input int ec, input logic [63:0] epc);
    vec_t r;
    r.fv = f; r.dr = d; r.fl = l; r.pc = pc; r.ev = ev; r.er = er; r.ec = ec; r.epc = epc;
    return r;
  endfunction
  task automatic drive(input logic f, input logic d, input logic l, input fetch_entry_t e);
    @(negedge clk);
    fv = f; dr = d; flush = l; fin = e;
    #1;
  endtask
  initial begin
    fetch_entry_t e, head;
    int sz;
    logic byp, pu, po, ev;
    fin = '0;
    #2;
    chk("reset_valid", 256'(decode_valid), 256'(0));
    chk("reset_ready", 256'(fetch_ready), 256'(1));
    chk("reset_count", 256'(count), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    // first push becomes visible the following cycle
    drive(1, 0, 0, mk(64'h8000_0000));
    chk("first_same_cycle_valid", 256'(decode_valid), 256'(0));
    drive(0, 0, 0, '0);
    chk("first_valid", 256'(decode_valid), 256'(1));
    chk("first_pc", 256'(dout.pc), 256'(64'h8000_0000));
    chk("first_instr", 256'(dout.instr), 256'(32'h8000_0013));
    chk("first_count", 256'(count), 256'(1));
    drive(0, 0, 1, '0);
    chk("flush_kills_valid", 256'(decode_valid), 256'(0));
    // fill, overfill, pop, push+pop with wrap, flush with push, refill
    tbl.push_back(v(1, 0, 0, 64'h100, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 64'h104, 1, 1, 1, 64'h100));
    tbl.push_back(v(1, 0, 0, 64'h108, 1, 1, 2, 64'h100));
    tbl.push_back(v(1, 0, 0, 64'h10C, 1, 1, 3, 64'h100));
    tbl.push_back(v(1, 0, 0, 64'h110, 1, 0, 4, 64'h100));
    tbl.push_back(v(1, 1, 0, 64'h114, 1, 0, 4, 64'h100));
    tbl.push_back(v(0, 1, 0, 64'h0,   1, 1, 3, 64'h104));
    tbl.push_back(v(1, 1, 0, 64'h200, 1, 1, 2, 64'h108));
    tbl.push_back(v(1, 1, 0, 64'h204, 1, 1, 2, 64'h10C));
    tbl.push_back(v(1, 1, 0, 64'h208, 1, 1, 2, 64'h200));
    tbl.push_back(v(1, 1, 0, 64'h20C, 1, 1, 2, 64'h204));
    tbl.push_back(v(1, 1, 0, 64'h210, 1, 1, 2, 64'h208));
    tbl.push_back(v(1, 1, 0, 64'h214, 1, 1, 2, 64'h20C));
    tbl.push_back(v(1, 0, 0, 64'h218, 1, 1, 2, 64'h210));
    tbl.push_back(v(1, 1, 1, 64'h21C, 0, 1, 3, 64'h0));
    tbl.push_back(v(0, 0, 0, 64'h0,   0, 1, 0, 64'h0));
    tbl.push_back(v(1, 0, 0, 64'h300, 0, 1, 0, 64'h0));
    tbl.push_back(v(0, 1, 0, 64'h0,   1, 1, 1, 64'h300));
    tbl.push_back(v(0, 0, 0, 64'h0,   0, 1, 0, 64'h0));
    foreach (tbl[i]) begin
      drive(tbl[i].fv, tbl[i].dr, tbl[i].fl, mk(tbl[i].pc));
      chk($sformatf("tbl%0d_valid", i), 256'(decode_valid), 256'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 256'(fetch_ready), 256'(tbl[i].er));
      chk($sformatf("tbl%0d_count", i), 256'(count), 256'(tbl[i].ec));
      if (tbl[i].ev) chk($sformatf("tbl%0d_head", i), 256'(dout), 256'(mk(tbl[i].epc)));
    end
    // empty queue with decoder ready: bypass forwards same cycle, otherwise one cycle later
    drive(1, 1, 0, mk(64'h200));
`ifdef DECODE_QUEUE_BYPASS_EN
    chk("byp_valid", 256'(decode_valid), 256'(1));
    chk("byp_pc", 256'(dout.pc), 256'(64'h200));
    chk("byp_count", 256'(count), 256'(0));
    drive(0, 1, 0, '0);
    chk("byp_next_valid", 256'(decode_valid), 256'(0));
    chk("byp_next_count", 256'(count), 256'(0));
`else
    chk("nobyp_valid", 256'(decode_valid), 256'(0));
    drive(0, 1, 0, '0);
    chk("nobyp_next_valid", 256'(decode_valid), 256'(1));
    chk("nobyp_next_pc", 256'(dout.pc), 256'(64'h200));
    chk("nobyp_next_count", 256'(count), 256'(1));
    drive(0, 0, 0, '0);
    chk("nobyp_drained", 256'(count), 256'(0));
`endif
    // asynchronous reset with two entries held
    drive(1, 0, 0, mk(64'h400));
    drive(1, 0, 0, mk(64'h404));
    drive(0, 0, 0, '0);
    chk("pre_rst_count", 256'(count), 256'(2));
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 256'(decode_valid), 256'(0));
    chk("async_rst_count", 256'(count), 256'(0));
    chk("async_rst_ready", 256'(fetch_ready), 256'(1));
    @(negedge clk);
    rst = 1'b0;
    // randomized traffic against a queue model
    model.delete();
    for (int c = 0; c < 2000; c++) begin
      e = rnd_entry();
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 40) == 0, e);
      sz = model.size();
`ifdef DECODE_QUEUE_BYPASS_EN
      byp = sz == 0 && fv && dr && !flush;
`else
      byp = 1'b0;
`endif
      ev = (sz != 0 || byp) && !flush;
      head = byp ? e : (sz != 0 ? model[0] : '0);
      chk("rnd_valid", 256'(decode_valid), 256'(ev));
      chk("rnd_ready", 256'(fetch_ready), 256'(sz < DEPTH));
      chk("rnd_count", 256'(count), 256'(sz));
      if (ev) chk("rnd_head", 256'(dout), 256'(head));
      if (flush) model.delete();
      else begin
        po = sz != 0 && dr;
        pu = fv && sz < DEPTH && !byp;
        if (po) void'(model.pop_front());
        if (pu) model.push_back(e);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
